// File: rtl/draw_pkg.sv
// Shared types and dimension constants for the draw engine and its scan counter.
package draw_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      FLUSH = 2'd2
   } drawState_e;

   localparam int SCREEN_W_DEF = 160;
   localparam int SCREEN_H_DEF = 120;
   localparam int SPRITE_W_DEF = 40;
   localparam int SPRITE_H_DEF = 40;
   localparam int SCREEN_AW    = 15;
   localparam int SPRITE_AW    = 11;

   localparam logic [2:0] KEY_COLOR_DEF = 3'b101;

endpackage

// File: rtl/draw_scan_counter.sv
// Row-major col/row/linear-address stepper; the address advances by one per step.
// wrap flags the last column, last flags the last row; both together mark the final address.
module draw_scan_counter #(
   parameter int W  = 160,
   parameter int H  = 120,
   parameter int AW = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          step,
   output logic [7:0]    col,
   output logic [6:0]    row,
   output logic [AW-1:0] addr,
   output logic          wrap,
   output logic          last
);

   assign wrap = (col == 8'(W - 1));
   assign last = (row == 7'(H - 1));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         col  <= '0;
         row  <= '0;
         addr <= '0;
      end else if (step) begin
         if (wrap && last) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
         end else if (wrap) begin
            col  <= '0;
            row  <= row + 7'd1;
            addr <= addr + AW'(1);
         end else begin
            col  <= col + 8'd1;
            addr <= addr + AW'(1);
         end
      end
   end

endmodule

// File: rtl/draw_engine.sv
// Scans a full screen or a sprite, absorbs the one-cycle ROM latency and emits
// a clipped, colour-keyed pixel stream to the VGA adapter.
module draw_engine
   import draw_pkg::*;
#(
   parameter int         SCREEN_W  = SCREEN_W_DEF,
   parameter int         SCREEN_H  = SCREEN_H_DEF,
   parameter int         SPRITE_W  = SPRITE_W_DEF,
   parameter int         SPRITE_H  = SPRITE_H_DEF,
   parameter logic [2:0] KEY_COLOR = KEY_COLOR_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 isSprite,
   input  logic                 black,
   input  logic [7:0]           xOrigin,
   input  logic [6:0]           yOrigin,
   input  logic [4:0]           memorySelIn,
   input  logic [2:0]           romColor,
   output logic [4:0]           memorySel,
   output logic [SCREEN_AW-1:0] screenCount,
   output logic [SPRITE_AW-1:0] spriteCount,
   output logic [7:0]           x,
   output logic [6:0]           y,
   output logic [2:0]           color,
   output logic                 plot,
   output logic                 busy,
   output logic                 done,
   output drawState_e           stateDbg
);

   drawState_e state, stateNext;
   logic       isSpriteQ, blackQ;
   logic [7:0] xOriginQ;
   logic [6:0] yOriginQ;
   logic       accept, scanning, scanEnd;

   logic [7:0]           scrCol, sprCol, colSel, colQ;
   logic [6:0]           scrRow, sprRow, rowSel, rowQ;
   logic [SCREEN_AW-1:0] scrAddr;
   logic [SPRITE_AW-1:0] sprAddr;
   logic                 scrWrap, scrLast, sprWrap, sprLast;
   logic                 validQ, clipped, keyed;
   logic [8:0]           xSum;
   logic [7:0]           ySum;

   assign accept   = (state == IDLE) && start;
   assign scanning = (state == SCAN);
   assign scanEnd  = isSpriteQ ? (sprWrap && sprLast) : (scrWrap && scrLast);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         isSpriteQ <= 1'b0;
         blackQ    <= 1'b0;
         xOriginQ  <= '0;
         yOriginQ  <= '0;
         memorySel <= '0;
      end else begin
         state <= stateNext;
         if (accept) begin
            isSpriteQ <= isSprite;
            blackQ    <= black;
            xOriginQ  <= xOrigin;
            yOriginQ  <= yOrigin;
            memorySel <= memorySelIn;
         end
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start) stateNext = SCAN;
         SCAN:    if (scanEnd) stateNext = FLUSH;
         FLUSH:   stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   draw_scan_counter #(.W(SCREEN_W), .H(SCREEN_H), .AW(SCREEN_AW)) screenScan (
      .clk(clk), .reset(reset), .clear(accept), .step(scanning && !isSpriteQ),
      .col(scrCol), .row(scrRow), .addr(scrAddr), .wrap(scrWrap), .last(scrLast)
   );

   draw_scan_counter #(.W(SPRITE_W), .H(SPRITE_H), .AW(SPRITE_AW)) spriteScan (
      .clk(clk), .reset(reset), .clear(accept), .step(scanning && isSpriteQ),
      .col(sprCol), .row(sprRow), .addr(sprAddr), .wrap(sprWrap), .last(sprLast)
   );

   assign colSel = isSpriteQ ? sprCol : scrCol;
   assign rowSel = isSpriteQ ? sprRow : scrRow;

   // The pixel stage travels alongside the ROM read so romColor lines up with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         validQ <= 1'b0;
         colQ   <= '0;
         rowQ   <= '0;
      end else begin
         validQ <= scanning;
         colQ   <= colSel;
         rowQ   <= rowSel;
      end
   end

   assign xSum    = isSpriteQ ? ({1'b0, xOriginQ} + {1'b0, colQ}) : {1'b0, colQ};
   assign ySum    = isSpriteQ ? ({1'b0, yOriginQ} + {1'b0, rowQ}) : {1'b0, rowQ};
   assign clipped = (xSum >= 9'(SCREEN_W)) || (ySum >= 8'(SCREEN_H));
   assign keyed   = isSpriteQ && !blackQ && (romColor == KEY_COLOR);

   assign x     = xSum[7:0];
   assign y     = ySum[6:0];
   assign color = (validQ && !blackQ) ? romColor : 3'b000;
   assign plot  = validQ && !clipped && !keyed;

   assign screenCount = (scanning && !isSpriteQ) ? scrAddr : '0;
   assign spriteCount = (scanning && isSpriteQ) ? sprAddr : '0;
   assign busy        = (state != IDLE);
   assign done        = (state == FLUSH);
   assign stateDbg    = state;

endmodule

// File: tb/tb_draw_engine.sv
// Bench for draw_engine: table of draws, random sprite draws, mid-draw start and reset sequences.
module tb_draw_engine;
   import draw_pkg::*;

   logic       clk = 1'b0;
   logic       reset, start, isSprite, black;
   logic [7:0] xOrigin;
   logic [6:0] yOrigin;
   logic [4:0] memorySelIn;
   logic [2:0] romColor = 3'b111;
   logic [4:0] memorySel;
   logic [14:0] screenCount;
   logic [10:0] spriteCount;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] color;
   logic       plot, busy, done;
   drawState_e stateDbg;

   int vectors = 0;
   int miscompares = 0;

   int romMode = 0;
   int romSeed = 0;
   bit curSprite = 1'b0;

   logic [17:0] exp_q[$];

   typedef struct {
      bit isSpr;
      bit blk;
      int xo;
      int yo;
      int msel;
      int mode;
      int expPlots;
      int expFirst;
      int midStartAt;
   } vec_t;

   vec_t vecs[6];

   draw_engine dut (
      .clk(clk), .reset(reset), .start(start), .isSprite(isSprite), .black(black),
      .xOrigin(xOrigin), .yOrigin(yOrigin), .memorySelIn(memorySelIn), .romColor(romColor),
      .memorySel(memorySel), .screenCount(screenCount), .spriteCount(spriteCount),
      .x(x), .y(y), .color(color), .plot(plot), .busy(busy), .done(done), .stateDbg(stateDbg)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] romFn(int mode, int addr, int seed);
      case (mode)
         0:       return 3'(addr & 7);
         1:       return 3'b010;
         2:       return (addr % 2 == 0) ? KEY_COLOR_DEF : 3'b011;
         default: return 3'((addr * 5 + addr / 7 + seed) & 7);
      endcase
   endfunction

   // Synchronous ROM model: q follows the driven address by one clock.
   always @(posedge clk)
      romColor <= romFn(romMode, curSprite ? int'(spriteCount) : int'(screenCount), romSeed);

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic runDraw(input vec_t v);
      int w, h, n, xs, ys, addr, cyc, modelCount, expPlots;
      int plots, firstPlot, doneCyc, doneCnt, busyLow, addrBad, pixBad, selBad, lastAddr, probe;
      logic [2:0] q, col;
      logic [17:0] got, e;
      w = v.isSpr ? 40 : 160;
      h = v.isSpr ? 40 : 120;
      n = w * h;
      exp_q.delete();
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            xs = v.isSpr ? v.xo + c : c;
            ys = v.isSpr ? v.yo + r : r;
            addr = r * w + c;
            q = romFn(v.mode, addr, romSeed);
            col = v.blk ? 3'b000 : q;
            if (xs < 160 && ys < 120 && !(v.isSpr && !v.blk && q == KEY_COLOR_DEF))
               exp_q.push_back({8'(xs), 7'(ys), col});
         end
      end
      modelCount = exp_q.size();
      expPlots = (v.expPlots < 0) ? modelCount : v.expPlots;

      @(negedge clk);
      isSprite = v.isSpr;
      black = v.blk;
      xOrigin = 8'(v.xo);
      yOrigin = 7'(v.yo);
      memorySelIn = 5'(v.msel);
      curSprite = v.isSpr;
      romMode = v.mode;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      // Scramble the request inputs: the DUT must hold the values latched at start.
      isSprite = 1'($urandom_range(0, 1));
      black = 1'($urandom_range(0, 1));
      xOrigin = 8'($urandom_range(0, 255));
      yOrigin = 7'($urandom_range(0, 127));
      memorySelIn = 5'($urandom_range(0, 31));

      plots = 0; firstPlot = 0; doneCyc = 0; doneCnt = 0; busyLow = 0;
      addrBad = 0; pixBad = 0; selBad = 0; lastAddr = -1; probe = -1;
      for (cyc = 1; cyc <= n + 6; cyc++) begin
         @(negedge clk);
         if (cyc == v.midStartAt) start = 1'b1;
         if (cyc == v.midStartAt + 1) start = 1'b0;
         if (cyc <= n) begin
            if (v.isSpr && (int'(spriteCount) != cyc - 1 || screenCount != 0)) addrBad++;
            if (!v.isSpr && (int'(screenCount) != cyc - 1 || spriteCount != 0)) addrBad++;
            if (cyc == n) lastAddr = v.isSpr ? int'(spriteCount) : int'(screenCount);
         end
         if (busy && int'(memorySel) != v.msel) selBad++;
         if (plot) begin
            plots++;
            if (firstPlot == 0) firstPlot = cyc;
            got = {x, y, color};
            if (exp_q.size() == 0) pixBad++;
            else begin
               e = exp_q.pop_front();
               if (got !== e) pixBad++;
            end
            if (!v.isSpr && x == 8'd5 && y == 7'd2) probe = int'(color);
         end
         if (done) begin
            doneCnt++;
            if (doneCyc == 0) doneCyc = cyc;
         end
         if (!busy && busyLow == 0) busyLow = cyc;
      end
      pixBad += exp_q.size();

      check("plot_count", plots, expPlots);
      check("pixel_stream_errors", pixBad, 0);
      check("done_cycle", doneCyc, n + 1);
      check("done_count", doneCnt, 1);
      check("busy_low_cycle", busyLow, n + 2);
      check("address_sequence_errors", addrBad, 0);
      check("last_address", lastAddr, n - 1);
      check("memory_sel_errors", selBad, 0);
      if (v.expFirst > 0) check("first_plot_cycle", firstPlot, v.expFirst);
      if (!v.isSpr && !v.blk && v.mode == 0) check("pixel_5_2_color", probe, 5);
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_memorySel"}, int'(memorySel), 0);
      check({tag, "_screenCount"}, int'(screenCount), 0);
      check({tag, "_spriteCount"}, int'(spriteCount), 0);
      check({tag, "_x"}, int'(x), 0);
      check({tag, "_y"}, int'(y), 0);
      check({tag, "_color"}, int'(color), 0);
      check({tag, "_plot"}, int'(plot), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
   endtask

   initial begin
      vec_t rv;
      reset = 1'b1; start = 1'b0; isSprite = 1'b0; black = 1'b0;
      xOrigin = '0; yOrigin = '0; memorySelIn = '0;

      //            spr blk  xo   yo msel mode plots first mid
      vecs[0] = '{1'b0, 1'b0,   0,   0,  3,  0, 19200, 2,  0};
      vecs[1] = '{1'b1, 1'b0,  10,  20,  7,  1,  1600, 2,  0};
      vecs[2] = '{1'b1, 1'b0, 150, 100,  9,  1,   200, 2,  0};
      vecs[3] = '{1'b1, 1'b0,  30,  40, 12,  2,   800, 3,  0};
      vecs[4] = '{1'b1, 1'b1,  30,  40, 12,  2,  1600, 2,  0};
      vecs[5] = '{1'b1, 1'b0,   0,   0, 21,  3,    -1, 0, 300};

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkAllZero("reset");
      reset = 1'b0;

      for (int i = 0; i < 6; i++) runDraw(vecs[i]);

      for (int i = 0; i < 5; i++) begin
         romSeed = int'($urandom_range(0, 7));
         rv = '{1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
                int'($urandom_range(1, 3)), -1, 0, 0};
         runDraw(rv);
      end

      // Reset in the middle of a screen draw, then a fresh draw from address 0.
      @(negedge clk);
      isSprite = 1'b0; black = 1'b0; memorySelIn = 5'd4;
      curSprite = 1'b0; romMode = 0; romSeed = 0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 500; cyc++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkAllZero("midreset");
      reset = 1'b0;
      runDraw(vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/draw_engine.md
# draw_engine

Sequencing stage between the game FSM and the VGA adapter. On a single `start` request it scans either a full 160×120 background screen or a 40×40 sprite at a given origin. It drives the ROM read address and memory select, then absorbs the one-cycle ROM read latency. It emits an aligned `x`/`y`/`color`/`plot` pixel stream, with clipping, colour-key transparency and black fill.

## Interface
- `SCREEN_W`, 160: screen width in pixels.
- `SCREEN_H`, 120: screen height in pixels.
- `SPRITE_W`, 40: sprite width.
- `SPRITE_H`, 40: sprite height.
- `KEY_COLOR`, 3'b101: sprite transparent colour.

- `clk` in 1: single clock; all ROMs and the VGA adapter run on it.
- `reset` in 1: synchronous, active-high.
- `start` in 1: draw request; sampled only in IDLE.
- `isSprite` in 1: 1 selects a sprite draw, 0 a full-screen draw.
- `black` in 1: forces every pixel to 3'b000 and disables the colour key.
- `xOrigin` in 8: sprite left column; ignored for screens.
- `yOrigin` in 7: sprite top row; ignored for screens.
- `memorySelIn` in 5: ROM select; latched at start.
- `romColor` in 3: selected ROM `q`, valid one cycle after its address.
- `memorySel` out 5: latched select that drives the colour mux.
- `screenCount` out 15: screen ROM address.
- `spriteCount` out 11: sprite ROM address.
- `x` out 8, `y` out 7, `color` out 3: pixel to the VGA adapter.
- `plot` out 1: write strobe.
- `busy` out 1: high while a draw is in progress.
- `done` out 1: one-cycle pulse when a draw completes.

## Operation
- States:
  - IDLE: `start` → SCAN; origin, `isSprite`, `black` and `memorySelIn` are latched.
  - SCAN: one address per cycle, row-major; after the last address → FLUSH.
  - FLUSH: one cycle that drains the ROM latency stage; `done`=1, then → IDLE.
- Scan counters: `col` runs 0..W-1 and `row` runs 0..H-1.
  - The address increments by 1 each SCAN cycle and is never computed by multiplication.
  - Screen: `screenCount` = 0..19199, `x`=col, `y`=row.
  - Sprite: `spriteCount` = 0..1599, `x`=xOrigin+col, `y`=yOrigin+row.
  - Sprite sums are computed 1 bit wider than `x`/`y` for the clip test.
- Pixel stage: `col`, `row` and a valid bit are registered one cycle, alongside the ROM read. `plot` = stage valid AND not clipped AND not keyed.
  - Clipped: sum x ≥ 160 or sum y ≥ 120.
  - Keyed: sprite, `black`=0 and `romColor`==KEY_COLOR.
- Colour: `color` = `black` ? 3'b000 : `romColor`.
- Suppressed pixels still consume their cycle; the address sequence never stalls.
- The address that is not in use holds at 0.
- `start` while `busy` is ignored. No queueing.
- `reset` at any time:
  - state goes to IDLE, the pixel stage is invalidated and counters clear;
  - `plot`, `done` and `busy` are 0 in the cycle after the reset edge.

## Timing
- Reset values: every output is 0, including `memorySel`, `x`, `y`, `color`, both addresses, `plot`, `busy` and `done`.
- Edge E0: `start` is sampled.
- Cycle 1 after E0: `busy`=1 and address 0 is driven.
- Cycle k+1: address k is driven. N = 19200 for a screen, 1600 for a sprite.
- Cycle k+2: pixel k appears on `x`/`y`/`color`, with `plot` if not suppressed. Latency from address to pixel is exactly 1 cycle.
- Cycle N+1: last pixel; state is FLUSH, `done`=1, `busy`=1.
- Cycle N+2: `busy`=0, IDLE; a new `start` may be sampled on this edge.
- Start-to-start minimum: N+2 cycles.
- `done` and the final pixel coincide.

## Structure
- Package `draw_pkg` holds:
  - the state enum {IDLE, SCAN, FLUSH};
  - the screen and sprite dimension constants;
  - address widths 15 and 11;
  - the KEY_COLOR default.
- Sub-module `draw_scan_counter` provides the col/row/linear-address stepping with `wrap` and `last` flags, parameterised by W and H.
- Top-level `draw_engine` holds the FSM, the latency stage and the clip/key logic.

## Test plan
- Screen draw, `memorySelIn`=3, ROM model q = addr[2:0]:
  - 19200 plots;
  - pixel (x=5,y=2) has colour (325)&7=5;
  - `done` at cycle 19201, `busy` low at 19202.
- Sprite at (10,20), ROM all 3'b010:
  - 1600 plots, x 10..49 and y 20..59;
  - the first plot is at cycle 2;
  - `spriteCount` ends at 1599.
- Sprite at (150,100):
  - only cols 0..9 and rows 0..19 plot, 200 plots in total;
  - `done` still arrives at cycle 1601.
- Colour key, sprite ROM = KEY_COLOR at even addresses:
  - 800 plots;
  - repeated with `black`=1: 1600 plots, all colour 0.
- `start` pulsed mid-draw: ignored, with exactly one `done`.
- `reset` at cycle 500 of a screen draw:
  - next cycle `plot`=`busy`=0;
  - a subsequent start restarts at address 0.
